// File: rtl/pfb_coef_loader_pkg.sv
// Shared PFB definitions: default coefficient-memory geometry and the
// coefficient loader state encoding.
package pfb_coef_loader_pkg;

  localparam int PFB_NUM_TAPS = 80;
  localparam int PFB_ADDR_W   = 7;
  localparam int PFB_DATA_W   = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ZFILL = 2'd2,
    ST_DRAIN = 2'd3
  } loader_state_e;

endpackage

// File: rtl/pfb_coef_loader.sv
// Streams one frame of NUM_TAPS coefficient words into the coefficient memory
// write port, zero-filling short frames and discarding the tail of long ones.
module pfb_coef_loader
  import pfb_coef_loader_pkg::*;
#(
  parameter int NUM_TAPS = PFB_NUM_TAPS,
  parameter int ADDR_W   = PFB_ADDR_W,
  parameter int DATA_W   = PFB_DATA_W
) (
  input  logic              clk,
  input  logic              sync_reset_n,
  input  logic              s_axis_tvalid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dia,
  output logic              load_active,
  output logic              load_done,
  output logic              err_short,
  output logic              err_long,
  output loader_state_e     state_dbg
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAPS - 1);

  // Handshake: a word moves when s_axis_tvalid and s_axis_tready are both high
  // at a rising edge; tready is registered and depends only on loader state.
  loader_state_e     state_q, state_n;
  logic [ADDR_W-1:0] cnt_q, cnt_n;
  logic              wea_n, done_n, err_short_n, err_long_n, active_n, tready_n;
  logic [ADDR_W-1:0] addra_n;
  logic [DATA_W-1:0] dia_n;
  logic              xfer;

  assign xfer      = s_axis_tvalid && s_axis_tready;
  assign state_dbg = state_q;

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    wea_n       = 1'b0;
    addra_n     = addra;
    dia_n       = dia;
    done_n      = 1'b0;
    err_short_n = err_short;
    err_long_n  = err_long;
    case (state_q)
      // The counter sits at 0 in IDLE, so the first word of a frame takes
      // exactly the same path as any later word.
      ST_IDLE, ST_LOAD: begin
        if (xfer) begin
          wea_n   = 1'b1;
          addra_n = cnt_q;
          dia_n   = s_axis_tdata;
          if (state_q == ST_IDLE) begin
            err_short_n = 1'b0;
            err_long_n  = 1'b0;
          end
          if (cnt_q == LAST_IDX) begin
            cnt_n = '0;
            if (s_axis_tlast) begin
              done_n  = 1'b1;
              state_n = ST_IDLE;
            end else begin
              err_long_n = 1'b1;
              state_n    = ST_DRAIN;
            end
          end else begin
            cnt_n = cnt_q + 1'b1;
            if (s_axis_tlast) begin
              err_short_n = 1'b1;
              state_n     = ST_ZFILL;
            end else begin
              state_n = ST_LOAD;
            end
          end
        end
      end
      ST_ZFILL: begin
        wea_n   = 1'b1;
        addra_n = cnt_q;
        dia_n   = '0;
        if (cnt_q == LAST_IDX) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (xfer && s_axis_tlast) state_n = ST_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
    // Any write landing while the next state is IDLE is the final write of a frame.
    active_n = (state_n != ST_IDLE) || wea_n;
    tready_n = (state_n != ST_ZFILL);
  end

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      wea           <= 1'b0;
      addra         <= '0;
      dia           <= '0;
      load_done     <= 1'b0;
      err_short     <= 1'b0;
      err_long      <= 1'b0;
      load_active   <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      wea           <= wea_n;
      addra         <= addra_n;
      dia           <= dia_n;
      load_done     <= done_n;
      err_short     <= err_short_n;
      err_long      <= err_long_n;
      load_active   <= active_n;
      s_axis_tready <= tready_n;
    end
  end

endmodule

// File: tb/tb_pfb_coef_loader.sv
// Self-checking bench for pfb_coef_loader: vector table, multi-cycle corner
// sequences and random frames against a frame-level reference model.
module tb_pfb_coef_loader;
  import pfb_coef_loader_pkg::*;

  localparam int N  = 80;
  localparam int AW = 7;
  localparam int DW = 25;
  localparam int EW = AW + DW;

  logic          clk = 1'b0;
  logic          sync_reset_n;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          wea, load_active, load_done, err_short, err_long;
  logic [AW-1:0] addra;
  logic [DW-1:0] dia;
  loader_state_e state_dbg;

  pfb_coef_loader #(.NUM_TAPS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .sync_reset_n(sync_reset_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .wea(wea), .addra(addra), .dia(dia),
    .load_active(load_active), .load_done(load_done),
    .err_short(err_short), .err_long(err_long), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int gap_pct;
    bit rnd_data;
    int exp_done;
    bit exp_es;
    bit exp_el;
    int exp_tr_low;
  } vec_t;

  vec_t          vecs[8];
  logic [DW-1:0] words[$];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] act_q[$];
  int            done_cyc_q[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, done_cnt = 0, inv_err = 0, tr_low = 0, run = 0, max_run = 0;

  // Monitor: samples outputs on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (wea) begin
      act_q.push_back({addra, dia});
      run++;
      if (run > max_run) max_run = run;
      if (!load_active) inv_err++;
    end else begin
      run = 0;
    end
    if (load_done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
      if (!wea || addra != AW'(N - 1)) inv_err++;
    end
    if (!s_axis_tready) tr_low++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start_test();
    words.delete();
    exp_q.delete();
    act_q.delete();
    done_cyc_q.delete();
    done_cnt = 0; inv_err = 0; tr_low = 0; run = 0; max_run = 0;
  endtask

  task automatic fill_words(input int len, input bit rnd);
    for (int i = 0; i < len; i++)
      words.push_back(rnd ? DW'($urandom) : DW'(i + 1));
  endtask

  // Reference model: a frame always rewrites all N addresses; words past N are
  // dropped and missing words read back as zero.
  task automatic build_exp(input int start, input int len);
    for (int a = 0; a < N; a++)
      exp_q.push_back({AW'(a), (a < len) ? words[start + a] : DW'(0)});
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send_words(input int start, input int len, input int gap_pct, input bit do_last);
    bit acc;
    int waited;
    for (int i = 0; i < len; i++) begin
      if (gap_pct > 0) begin
        while ($urandom_range(99) < gap_pct) begin
          s_axis_tvalid = 1'b0;
          s_axis_tlast  = 1'b0;
          align();
        end
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = words[start + i];
      s_axis_tlast  = do_last && (i == len - 1);
      waited = 0;
      do begin
        @(negedge clk);
        acc = s_axis_tready;
        align();
        waited++;
      end while (!acc && waited < 200);
      if (!acc) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic check_writes(input string name);
    int mism = 0;
    chk({name, "_nwrites"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) mism++;
    chk({name, "_write_mism"}, mism, 0);
  endtask

  task automatic check_frame(input string name, input int e_done, input bit e_es,
                             input bit e_el, input int e_tr_low);
    int w = 0;
    while (load_active && w < 400) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    chk({name, "_idle_timeout"}, load_active, 0);
    check_writes(name);
    chk({name, "_load_done"}, done_cnt, e_done);
    chk({name, "_err_short"}, err_short, e_es);
    chk({name, "_err_long"}, err_long, e_el);
    chk({name, "_tready_low"}, tr_low, e_tr_low);
    chk({name, "_invariant"}, inv_err, 0);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_wea"}, wea, 0);
    chk({name, "_addra"}, addra, 0);
    chk({name, "_dia"}, dia, 0);
    chk({name, "_load_done"}, load_done, 0);
    chk({name, "_err_short"}, err_short, 0);
    chk({name, "_err_long"}, err_long, 0);
    chk({name, "_load_active"}, load_active, 0);
    chk({name, "_tready"}, s_axis_tready, 0);
    chk({name, "_state_idle"}, state_dbg == ST_IDLE, 1);
  endtask

  initial begin
    vecs[0] = '{80, 0,  0, 1, 0, 0, 0};
    vecs[1] = '{50, 0,  0, 0, 1, 0, 30};
    vecs[2] = '{90, 0,  0, 0, 0, 1, 0};
    vecs[3] = '{80, 0,  1, 1, 0, 0, 0};
    vecs[4] = '{1,  0,  1, 0, 1, 0, 79};
    vecs[5] = '{79, 0,  1, 0, 1, 0, 1};
    vecs[6] = '{81, 0,  1, 0, 0, 1, 0};
    vecs[7] = '{80, 40, 0, 1, 0, 0, 0};

    sync_reset_n  = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    align();
    sync_reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("por_tready_release", s_axis_tready, 1);

    for (int v = 0; v < 8; v++) begin
      start_test();
      fill_words(vecs[v].len, vecs[v].rnd_data);
      build_exp(0, vecs[v].len);
      align();
      send_words(0, vecs[v].len, vecs[v].gap_pct, 1'b1);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_es,
                  vecs[v].exp_el, vecs[v].exp_tr_low);
    end

    // Two gapless frames back to back
    start_test();
    fill_words(2 * N, 1'b1);
    build_exp(0, N);
    build_exp(N, N);
    align();
    send_words(0, N, 0, 1'b1);
    send_words(N, N, 0, 1'b1);
    check_frame("b2b", 2, 0, 0, 0);
    chk("b2b_write_run", max_run, 2 * N);
    chk("b2b_done_spacing",
        (done_cyc_q.size() == 2) ? done_cyc_q[1] - done_cyc_q[0] : -1, N);

    // Reset mid-frame after word 40
    start_test();
    fill_words(40, 1'b1);
    for (int a = 0; a < 40; a++) exp_q.push_back({AW'(a), words[a]});
    align();
    send_words(0, 40, 0, 1'b0);
    sync_reset_n = 1'b0;
    @(negedge clk);
    align();
    sync_reset_n = 1'b1;
    @(negedge clk);
    check_reset("mid_reset");
    @(posedge clk);
    @(negedge clk);
    chk("mid_reset_tready_release", s_axis_tready, 1);
    chk("mid_reset_no_write", wea, 0);
    check_writes("mid_reset_partial");
    start_test();
    fill_words(N, 1'b1);
    build_exp(0, N);
    align();
    send_words(0, N, 0, 1'b1);
    check_frame("after_reset", 1, 0, 0, 0);

    // Random frames: length class, gaps and data all random
    for (int r = 0; r < 8; r++) begin
      int len;
      int gap;
      case ($urandom_range(2))
        0:       len = N;
        1:       len = $urandom_range(N - 1, 1);
        default: len = $urandom_range(N + 20, N + 1);
      endcase
      gap = $urandom_range(50);
      start_test();
      fill_words(len, 1'b1);
      build_exp(0, len);
      align();
      send_words(0, len, gap, 1'b1);
      check_frame($sformatf("rnd%0d_len%0d", r, len), (len == N) ? 1 : 0,
                  len < N, len > N, (len < N) ? N - len : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pfb_coef_loader.md
PFB_COEF_LOADER -- requirements
Module: pfb_coef_loader

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 80, the number of coefficient words per load frame (valid range 1..128).
REQ-002 SHALL have parameter ADDR_W, default 7, the coefficient memory address width.
REQ-003 SHALL have parameter DATA_W, default 25, the coefficient word width.
REQ-004 clk  in  1  single clock; all logic is on the rising edge.
REQ-005 sync_reset_n  in  1  synchronous reset, active-low.
REQ-006 s_axis_tvalid  in  1  coefficient word valid.
REQ-007 s_axis_tdata  in  DATA_W  coefficient word, two's complement.
REQ-008 s_axis_tlast  in  1  marks the last word of the frame.
REQ-009 s_axis_tready  out  1  loader can accept a word.
REQ-010 wea  out  1  write strobe to the coefficient memory write port.
REQ-011 addra  out  ADDR_W  write address.
REQ-012 dia  out  DATA_W  write data.
REQ-013 load_active  out  1  high while a frame is in progress, including zero-fill; downstream filter masks its output on it.
REQ-014 load_done  out  1  single-cycle pulse when a frame completes with exactly NUM_TAPS words.
REQ-015 err_short  out  1  sticky: the last frame ended early and was zero-filled.
REQ-016 err_long  out  1  sticky: the last frame exceeded NUM_TAPS words.

Function
REQ-017 SHALL implement the states IDLE, LOAD, ZFILL and DRAIN.
REQ-018 A transfer SHALL occur when s_axis_tvalid and s_axis_tready are both high; s_axis_tready SHALL be 1 in IDLE, LOAD and DRAIN, and 0 in ZFILL.
REQ-019 Each accepted word SHALL produce wea=1 one cycle later, registered, with dia = the accepted tdata and addra = word index (0..NUM_TAPS-1); wea SHALL otherwise be 0.
REQ-020 IDLE -> LOAD on the first transfer; that word uses address 0, and err_short and err_long are cleared in the same cycle.
REQ-021 In IDLE, a transfer with tlast=1 and NUM_TAPS=1 SHALL complete the frame directly: load_done is pulsed and the state stays IDLE.
REQ-022 In LOAD, a transfer at index NUM_TAPS-1 with tlast=1 SHALL:
- return the state to IDLE;
- pulse load_done coincident with the final wea.
REQ-023 In LOAD, a transfer with tlast=1 at an index below NUM_TAPS-1 SHALL:
- move the state to ZFILL;
- set err_short.
REQ-024 In ZFILL, the loader SHALL:
- write zero on one address per cycle, from the next address through NUM_TAPS-1;
- then return to IDLE with no load_done.
REQ-025 In LOAD, a transfer at index NUM_TAPS-1 with tlast=0 SHALL:
- write the word normally;
- move the state to DRAIN and set err_long.
REQ-026 DRAIN SHALL discard the accepted words (wea=0) until a transfer with tlast=1, then go to IDLE with no load_done.
REQ-027 load_active SHALL be 1 in LOAD, ZFILL and DRAIN, and for the cycle carrying the final wea of a frame; otherwise 0.
REQ-028 The address counter SHALL never exceed NUM_TAPS-1 and SHALL reset to 0 on every return to IDLE.
REQ-029 Throughput SHALL be one word per cycle, with no bubbles between back-to-back frames.

Reset
REQ-030 While sync_reset_n=0 at a clock edge, the block SHALL reset to: state IDLE, address counter 0, wea 0, addra 0, dia 0, load_done 0, err_short 0, err_long 0, load_active 0, s_axis_tready 0.
REQ-031 s_axis_tready SHALL go to 1 on the first cycle after reset is released.
REQ-032 A reset during a frame SHALL abandon the frame with no further writes; the memory is left partially written and the next frame fully rewrites it.

Structure
REQ-033 The state encoding and the default constants NUM_TAPS, ADDR_W and DATA_W SHALL live in the shared PFB package.
REQ-034 The block SHALL have no sub-modules: a single FSM with an address counter and an output register stage.

Verification
REQ-035 Frame of 80 words 1..80 with tlast on word 80 -> 80 writes, addra 0..79, dia 1..80, load_done exactly once with the write to addr 79, no errors.
REQ-036 Frame of 50 words with tlast on word 50 -> writes to addr 0..49 of the data, then zeros to addr 50..79 with tready=0 for 30 cycles, err_short=1, no load_done.
REQ-037 Frame of 90 words with tlast on word 90 -> 80 writes, words 81..90 dropped, err_long=1, no load_done; the next good frame clears err_long.
REQ-038 Two back-to-back 80-word frames with tvalid held high -> 160 consecutive write cycles and two load_done pulses, 80 cycles apart.
REQ-039 sync_reset_n=0 for one cycle after word 40 -> no write follows reset, all outputs at their reset values, and a fresh 80-word frame then loads from address 0.
REQ-040 Random tvalid gaps on an 80-word frame -> the written data and addresses match the gapless case, and load_done still pulses once.
